// File: rtl/button_debouncer_pkg.sv
// Shared types for the button debouncer: FSM state encoding and level decode.
package debounce_pkg;

    localparam logic [1:0] ENC_LOW        = 2'b00;
    localparam logic [1:0] ENC_MAYBE_HIGH = 2'b01;
    localparam logic [1:0] ENC_HIGH       = 2'b11;
    localparam logic [1:0] ENC_MAYBE_LOW  = 2'b10;

    typedef enum logic [1:0] {
        S_LOW        = ENC_LOW,
        S_MAYBE_HIGH = ENC_MAYBE_HIGH,
        S_HIGH       = ENC_HIGH,
        S_MAYBE_LOW  = ENC_MAYBE_LOW
    } debounce_state_t;

    // The debounced level is high while confirmed high or while a fall is still unconfirmed.
    function automatic logic state_level(debounce_state_t s);
        return (s == S_HIGH) || (s == S_MAYBE_LOW);
    endfunction

endpackage

// File: rtl/button_debouncer_if.sv
// Signal bundle between the debouncer and its driver/consumer; state is a debug tap.
interface button_debouncer_if #(parameter int N = 8);
    import debounce_pkg::*;

    // No handshake: tick is a one-cycle sample strobe qualified by ena, and
    // rising/falling are one-cycle strobes the consumer must take when they fire.
    logic            ena;
    logic            tick;
    logic [N-1:0]    stable_ticks;
    logic            button;
    logic            out;
    logic            rising;
    logic            falling;
    debounce_state_t state;

    modport master (
        output ena, tick, stable_ticks, button,
        input  out, rising, falling, state
    );

    modport slave (
        input  ena, tick, stable_ticks, button,
        output out, rising, falling, state
    );

endinterface

// File: rtl/button_debouncer_synchronizer.sv
// Two-flop, one-bit synchronizer for asynchronous inputs; clears both stages on reset.
module synchronizer (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic stage1;

    always_ff @(posedge clk) begin
        if (rst) begin
            stage1 <= 1'b0;
            q      <= 1'b0;
        end else begin
            stage1 <= d;
            q      <= stage1;
        end
    end

endmodule

// File: rtl/button_debouncer.sv
// Debounces a raw button into a clean level plus one-cycle rising/falling strobes,
// requiring max(stable_ticks,1) consecutive matching samples before the level flips.
module button_debouncer
    import debounce_pkg::*;
#(
    parameter int N = 8
) (
    input logic               clk,
    input logic               rst,
    button_debouncer_if.slave bus
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic            sync;
    debounce_state_t state_q, state_d;
    logic [N-1:0]    cnt_q, cnt_d, cnt_sat, thresh;
    logic [N:0]      cnt_inc;
    logic            reach, sample, rise_d, fall_d;
    logic            out_q, rising_q, falling_q;

    synchronizer u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.button),
        .q   (sync)
    );

    // cnt_inc is one bit wider so the threshold compare can never wrap.
    always_comb begin
        sample  = bus.ena & bus.tick;
        thresh  = (bus.stable_ticks == '0) ? ONE : bus.stable_ticks;
        cnt_inc = {1'b0, cnt_q} + {{N{1'b0}}, 1'b1};
        reach   = cnt_inc >= {1'b0, thresh};
        cnt_sat = (&cnt_q) ? cnt_q : cnt_inc[N-1:0];
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sample) begin
            case (state_q)
                S_LOW: begin
                    if (sync) begin
                        if (thresh == ONE) begin
                            state_d = S_HIGH;
                            cnt_d   = '0;
                            rise_d  = 1'b1;
                        end else begin
                            state_d = S_MAYBE_HIGH;
                            cnt_d   = ONE;
                        end
                    end
                end
                S_MAYBE_HIGH: begin
                    if (!sync) begin
                        state_d = S_LOW;
                        cnt_d   = '0;
                    end else if (reach) begin
                        state_d = S_HIGH;
                        cnt_d   = '0;
                        rise_d  = 1'b1;
                    end else begin
                        cnt_d   = cnt_sat;
                    end
                end
                S_HIGH: begin
                    if (!sync) begin
                        if (thresh == ONE) begin
                            state_d = S_LOW;
                            cnt_d   = '0;
                            fall_d  = 1'b1;
                        end else begin
                            state_d = S_MAYBE_LOW;
                            cnt_d   = ONE;
                        end
                    end
                end
                S_MAYBE_LOW: begin
                    if (sync) begin
                        state_d = S_HIGH;
                        cnt_d   = '0;
                    end else if (reach) begin
                        state_d = S_LOW;
                        cnt_d   = '0;
                        fall_d  = 1'b1;
                    end else begin
                        cnt_d   = cnt_sat;
                    end
                end
                default: begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_LOW;
            cnt_q     <= '0;
            out_q     <= 1'b0;
            rising_q  <= 1'b0;
            falling_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            out_q     <= state_level(state_d);
            rising_q  <= rise_d;
            falling_q <= fall_d;
        end
    end

    assign bus.out     = out_q;
    assign bus.rising  = rising_q;
    assign bus.falling = falling_q;
    assign bus.state   = state_q;

endmodule
